// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, shift types,
// forwarding selects and datapath width.
package exe_stage_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } ex_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_e;

    function automatic logic [DATA_W-1:0] rotr(
        input logic [DATA_W-1:0] v,
        input logic [4:0]        n
    );
        rotr = (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Execute-stage ALU with {N,Z,C,V} flag generation.
module exe_alu
    import exe_stage_pkg::*;
(
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [3:0]        sr_in,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        sr_out
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              arith;
    logic              c;
    logic              v;
    logic              unused_sr;

    assign unused_sr = ^sr_in[3:2];

    always_comb begin
        b     = val2;
        cin   = 1'b0;
        arith = 1'b0;
        // Subtraction is rn + ~val2 + cin, so carry-out is NOT borrow
        case (cmd)
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = sr_in[1]; end
            CMD_SUB: begin arith = 1'b1; b = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b = ~val2; cin = sr_in[1]; end
            default: ;
        endcase
        sum = {1'b0, rn} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

        res = '0;
        case (cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC,
            CMD_SUB, CMD_SBC: res = sum[DATA_W-1:0];
            CMD_AND: res = rn & val2;
            CMD_ORR: res = rn | val2;
            CMD_EOR: res = rn ^ val2;
            default: res = '0;
        endcase

        c = arith ? sum[DATA_W] : sr_in[1];
        v = arith ? ((rn[DATA_W-1] == b[DATA_W-1]) &&
                     (sum[DATA_W-1] != rn[DATA_W-1])) : sr_in[0];
        sr_out = {res[DATA_W-1], (res == '0), c, v};
    end

endmodule

// File: rtl/exe_stage_top.sv
// Execute stage: operand forwarding, Val2 shifter, ALU, branch target and
// EX/MEM register. Define FORWARDING_EN to enable the operand forward muxes.
module exe_stage_top #(
    parameter int DATA_W         = 32,
    parameter int REG_FILE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               instruction_in,
    input  logic [DATA_W-1:0]         val_Rn_in,
    input  logic [DATA_W-1:0]         val_Rm_in,
    input  logic [DATA_W-1:0]         MEM_stage_val,
    input  logic [DATA_W-1:0]         WB_stage_val,
    input  logic [1:0]                sel_src1,
    input  logic [1:0]                sel_src2,
    input  logic [3:0]                EX_command,
    input  logic [3:0]                SR_in,
    input  logic [11:0]               shifter_operand,
    input  logic [23:0]               signed_immediate,
    input  logic                      imm,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      WB_en_in,
    input  logic                      B_in,
    input  logic [REG_FILE_DEPTH-1:0] dst_in,
    output logic [DATA_W-1:0]         ALU_res,
    output logic [DATA_W-1:0]         val_Rm_out,
    output logic [31:0]               branch_address,
    output logic [31:0]               pc,
    output logic [31:0]               instruction,
    output logic [3:0]                SR_out,
    output logic [REG_FILE_DEPTH-1:0] dst_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      WB_en_out,
    output logic                      B_out,
    output logic [DATA_W-1:0]         mem_ALU_res,
    output logic [DATA_W-1:0]         mem_val_Rm,
    output logic [31:0]               mem_pc,
    output logic [31:0]               mem_instruction,
    output logic [REG_FILE_DEPTH-1:0] mem_dst,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      mem_WB_en
);

    import exe_stage_pkg::*;

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] val2;
    logic [4:0]        sh_amt;
    logic [4:0]        rot_amt;

`ifdef FORWARDING_EN
    always_comb begin
        src1 = val_Rn_in;
        src2 = val_Rm_in;
        case (sel_src1)
            FWD_MEM: src1 = MEM_stage_val;
            FWD_WB:  src1 = WB_stage_val;
            default: src1 = val_Rn_in;
        endcase
        case (sel_src2)
            FWD_MEM: src2 = MEM_stage_val;
            FWD_WB:  src2 = WB_stage_val;
            default: src2 = val_Rm_in;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, MEM_stage_val, WB_stage_val};
    assign src1 = val_Rn_in;
    assign src2 = val_Rm_in;
`endif

    assign sh_amt  = shifter_operand[11:7];
    assign rot_amt = {shifter_operand[11:8], 1'b0};

    // Memory ops use the raw 12-bit offset regardless of imm
    always_comb begin
        val2 = src2;
        if (mem_read_in || mem_write_in) begin
            val2 = {{(DATA_W-12){1'b0}}, shifter_operand};
        end else if (imm) begin
            val2 = rotr({{(DATA_W-8){1'b0}}, shifter_operand[7:0]}, rot_amt);
        end else if (sh_amt != 5'd0) begin
            case (shifter_operand[6:5])
                SH_LSL:  val2 = src2 << sh_amt;
                SH_LSR:  val2 = src2 >> sh_amt;
                SH_ASR:  val2 = $unsigned($signed(src2) >>> sh_amt);
                default: val2 = rotr(src2, sh_amt);
            endcase
        end
    end

    exe_alu u_alu (
        .cmd    (EX_command),
        .rn     (src1),
        .val2   (val2),
        .sr_in  (SR_in),
        .res    (ALU_res),
        .sr_out (SR_out)
    );

    assign val_Rm_out     = src2;
    assign branch_address = pc_in +
        {{6{signed_immediate[23]}}, signed_immediate, 2'b00};
    assign pc             = pc_in;
    assign instruction    = instruction_in;
    assign dst_out        = dst_in;
    assign mem_read_out   = mem_read_in;
    assign mem_write_out  = mem_write_in;
    assign WB_en_out      = WB_en_in;
    assign B_out          = B_in;

    logic [DATA_W-1:0]         alu_res_d, alu_res_q;
    logic [DATA_W-1:0]         val_rm_d, val_rm_q;
    logic [31:0]               pc_d, pc_q;
    logic [31:0]               instr_d, instr_q;
    logic [REG_FILE_DEPTH-1:0] dst_d, dst_q;
    logic                      rd_d, rd_q;
    logic                      wr_d, wr_q;
    logic                      wb_d, wb_q;

    always_comb begin
        alu_res_d = ALU_res;
        val_rm_d  = src2;
        pc_d      = pc_in;
        instr_d   = instruction_in;
        dst_d     = dst_in;
        rd_d      = mem_read_in;
        wr_d      = mem_write_in;
        wb_d      = WB_en_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_res_q <= '0;
            val_rm_q  <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            dst_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wb_q      <= 1'b0;
        end else begin
            alu_res_q <= alu_res_d;
            val_rm_q  <= val_rm_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            dst_q     <= dst_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wb_q      <= wb_d;
        end
    end

    assign mem_ALU_res     = alu_res_q;
    assign mem_val_Rm      = val_rm_q;
    assign mem_pc          = pc_q;
    assign mem_instruction = instr_q;
    assign mem_dst         = dst_q;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_WB_en       = wb_q;

endmodule

// File: tb/tb_exe_stage_top.sv
// Scoreboard bench for exe_stage_top against a behavioural reference model.
// Honours FORWARDING_EN the same way as the design build.
module tb_exe_stage_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instruction_in, val_Rn_in, val_Rm_in;
    logic [31:0] MEM_stage_val, WB_stage_val;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  EX_command, SR_in;
    logic [11:0] shifter_operand;
    logic [23:0] signed_immediate;
    logic        imm, mem_read_in, mem_write_in, WB_en_in, B_in;
    logic [3:0]  dst_in;
    logic [31:0] ALU_res, val_Rm_out, branch_address, pc, instruction;
    logic [3:0]  SR_out, dst_out;
    logic        mem_read_out, mem_write_out, WB_en_out, B_out;
    logic [31:0] mem_ALU_res, mem_val_Rm, mem_pc, mem_instruction;
    logic [3:0]  mem_dst;
    logic        mem_read, mem_write, mem_WB_en;

    always #5 clk = ~clk;

    exe_stage_top #(.DATA_W(32), .REG_FILE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
        .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
        .MEM_stage_val(MEM_stage_val), .WB_stage_val(WB_stage_val),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .EX_command(EX_command),
        .SR_in(SR_in), .shifter_operand(shifter_operand),
        .signed_immediate(signed_immediate), .imm(imm),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .WB_en_in(WB_en_in), .B_in(B_in), .dst_in(dst_in),
        .ALU_res(ALU_res), .val_Rm_out(val_Rm_out),
        .branch_address(branch_address), .pc(pc), .instruction(instruction),
        .SR_out(SR_out), .dst_out(dst_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .WB_en_out(WB_en_out), .B_out(B_out),
        .mem_ALU_res(mem_ALU_res), .mem_val_Rm(mem_val_Rm), .mem_pc(mem_pc),
        .mem_instruction(mem_instruction), .mem_dst(mem_dst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_WB_en(mem_WB_en)
    );

    typedef struct {
        logic [31:0] pc, instr, rn, rm, mv, wv;
        logic [1:0]  s1, s2;
        logic [3:0]  cmd, sr, dst;
        logic [11:0] so;
        logic [23:0] simm;
        logic        imm, rd, wr, wb, b;
    } stim_t;

    typedef struct {
        logic [31:0] alu, rm, br, pc, instr;
        logic [3:0]  sr, mask, dst;
        logic        rd, wr, wb, b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [31:0] y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel,
        input logic [31:0] r, input logic [31:0] m, input logic [31:0] w);
`ifdef FORWARDING_EN
        if (sel == 2'b01) return m;
        if (sel == 2'b10) return w;
`endif
        return r;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] op1, op2, v2, res;
        longint unsigned a, bb, r;
        longint      sa, sb, sv, off;
        int          amt, cin;
        logic        c, v;
        op1 = fwd(s.s1, s.rn, s.mv, s.wv);
        op2 = fwd(s.s2, s.rm, s.mv, s.wv);
        amt = int'(s.so[11:7]);
        if (s.rd || s.wr) v2 = {20'b0, s.so};
        else if (s.imm) v2 = ror32({24'b0, s.so[7:0]}, 2 * int'(s.so[11:8]));
        else if (s.so[6:5] == 2'b00) v2 = op2 << amt;
        else if (s.so[6:5] == 2'b01) v2 = op2 >> amt;
        else if (s.so[6:5] == 2'b10) v2 = $signed(op2) >>> amt;
        else v2 = ror32(op2, amt);
        a  = longint'(op1);
        bb = longint'(v2);
        sa = longint'($signed(op1));
        sb = longint'($signed(v2));
        c = s.sr[1];
        v = s.sr[0];
        cin = int'(s.sr[1]);
        e.mask = 4'hF;
        sv = 0;
        r = 0;
        res = 32'h0;
        case (s.cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd6: res = op1 & v2;
            4'd7: res = op1 | v2;
            4'd8: res = op1 ^ v2;
            4'd2, 4'd3: begin
                if (s.cmd == 4'd2) cin = 0;
                r = a + bb + longint'(cin);
                sv = sa + sb + longint'(cin);
                res = r[31:0];
                c = r[32];
            end
            4'd4, 4'd5: begin
                if (s.cmd == 4'd4) cin = 1;
                r = a - bb - longint'(1 - cin);
                sv = sa - sb - longint'(1 - cin);
                res = r[31:0];
                c = (a >= bb + longint'(1 - cin));
            end
            default: begin res = 32'h0; e.mask = 4'b1100; end
        endcase
        if (s.cmd inside {4'd2, 4'd3, 4'd4, 4'd5})
            v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        e.alu = res;
        e.sr  = {res[31], res == 32'h0, c, v};
        e.rm  = op2;
        off   = longint'($signed(s.simm)) * 4;
        e.br  = s.pc + off[31:0];
        e.pc  = s.pc;
        e.instr = s.instr;
        e.dst = s.dst;
        e.rd  = s.rd;
        e.wr  = s.wr;
        e.wb  = s.wb;
        e.b   = s.b;
        return e;
    endfunction

    function automatic stim_t zero_stim();
        stim_t s;
        s.pc = 0; s.instr = 0; s.rn = 0; s.rm = 0; s.mv = 0; s.wv = 0;
        s.s1 = 0; s.s2 = 0; s.cmd = 0; s.sr = 0; s.dst = 0; s.so = 0;
        s.simm = 0; s.imm = 0; s.rd = 0; s.wr = 0; s.wb = 0; s.b = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.pc = $urandom; s.instr = $urandom; s.rn = $urandom; s.rm = $urandom;
        s.mv = $urandom; s.wv = $urandom;
        s.s1 = 2'($urandom_range(0, 3)); s.s2 = 2'($urandom_range(0, 3));
        s.cmd = 4'($urandom_range(0, 15)); s.sr = 4'($urandom_range(0, 15));
        s.dst = 4'($urandom_range(0, 15)); s.so = 12'($urandom_range(0, 4095));
        s.simm = 24'($urandom_range(0, 24'hFFFFFF));
        s.imm = 1'($urandom_range(0, 1));
        s.rd = ($urandom_range(0, 7) == 0);
        s.wr = ($urandom_range(0, 7) == 0);
        s.wb = 1'($urandom_range(0, 1));
        s.b  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) s.rm = s.rn;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        pc_in = s.pc; instruction_in = s.instr; val_Rn_in = s.rn;
        val_Rm_in = s.rm; MEM_stage_val = s.mv; WB_stage_val = s.wv;
        sel_src1 = s.s1; sel_src2 = s.s2; EX_command = s.cmd; SR_in = s.sr;
        shifter_operand = s.so; signed_immediate = s.simm; imm = s.imm;
        mem_read_in = s.rd; mem_write_in = s.wr; WB_en_in = s.wb;
        B_in = s.b; dst_in = s.dst;
        q.push_back(model(s));
    endtask

    task automatic chk_mem_zero(input string tag);
        chk({tag, "_mem_ALU_res"}, mem_ALU_res, 32'h0);
        chk({tag, "_mem_val_Rm"}, mem_val_Rm, 32'h0);
        chk({tag, "_mem_pc"}, mem_pc, 32'h0);
        chk({tag, "_mem_instruction"}, mem_instruction, 32'h0);
        chk({tag, "_mem_ctrl"}, {25'b0, mem_dst, mem_read, mem_write, mem_WB_en},
            32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ALU_res", ALU_res, e.alu);
                chk("SR_out", {28'b0, SR_out & e.mask}, {28'b0, e.sr & e.mask});
                chk("val_Rm_out", val_Rm_out, e.rm);
                chk("branch_address", branch_address, e.br);
                chk("pc_instr", pc ^ instruction, e.pc ^ e.instr);
                chk("passthru", {23'b0, dst_out, mem_read_out, mem_write_out,
                    WB_en_out, B_out}, {23'b0, e.dst, e.rd, e.wr, e.wb, e.b});
                chk("mem_ALU_res", mem_ALU_res, e.alu);
                chk("mem_val_Rm", mem_val_Rm, e.rm);
                chk("mem_pc", mem_pc, e.pc);
                chk("mem_instruction", mem_instruction, e.instr);
                chk("mem_ctrl", {25'b0, mem_dst, mem_read, mem_write, mem_WB_en},
                    {25'b0, e.dst, e.rd, e.wr, e.wb});
            end
        end
    end

    initial begin : stim
        stim_t s;
        rst = 1'b0;
        s = zero_stim();
        drive(s);
        void'(q.pop_front());
        #3;
        chk_mem_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        s = zero_stim(); s.cmd = 4'd2; s.rn = 5; s.rm = 7;
        @(negedge clk); drive(s); #1;
        chk("add_res", ALU_res, 32'h0000000C);
        chk("add_sr", {28'b0, SR_out}, 32'h0);
        @(posedge clk); #2;
        chk("add_mem", mem_ALU_res, 32'h0000000C);

        s = zero_stim(); s.cmd = 4'd4; s.rn = 3; s.rm = 5;
        @(negedge clk); drive(s); #1;
        chk("sub_res", ALU_res, 32'hFFFFFFFE);
        chk("sub_sr", {28'b0, SR_out}, 32'h8);

        s = zero_stim(); s.cmd = 4'd1; s.imm = 1; s.so = 12'h4FF; s.sr = 4'b0011;
        @(negedge clk); drive(s); #1;
        chk("mov_res", ALU_res, 32'hFF000000);
        chk("mov_sr", {28'b0, SR_out}, 32'hB);

        s = zero_stim(); s.pc = 32'h100; s.simm = 24'hFFFFFE;
        @(negedge clk); drive(s); #1;
        chk("branch", branch_address, 32'h000000F8);

`ifdef FORWARDING_EN
        s = zero_stim(); s.cmd = 4'd2; s.rn = 1; s.rm = 1; s.s1 = 2'b01;
        s.mv = 32'h10;
        @(negedge clk); drive(s); #1;
        chk("fwd_mem", ALU_res, 32'h11);
        s.s1 = 2'b10; s.wv = 32'h20;
        @(negedge clk); drive(s); #1;
        chk("fwd_wb", ALU_res, 32'h21);
`endif

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive(rand_stim());
        end

        s = zero_stim(); s.cmd = 4'd2; s.rn = 5; s.so = 12'h003; s.rd = 1;
        s.wr = 1; s.wb = 1; s.dst = 4'hA; s.pc = 32'h1234;
        s.instr = 32'hDEADBEEF; s.rm = 32'h77;
        @(negedge clk); drive(s);
        @(posedge clk); #2;
        chk("preload_mem_pc", mem_pc, 32'h1234);
        rst = 1'b0;
        #1;
        chk_mem_zero("midrst");
        chk("rst_comb_alu", ALU_res, 32'h8);
        @(posedge clk); #1;
        chk_mem_zero("held_rst");
        @(negedge clk);
        rst = 1'b1;
        drive(rand_stim());
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(rand_stim());
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
